// File: rtl/syn_mod3.sv
// syn_mod3: unsigned WIDTH-bit operand modulo 3 via a balanced base-4 digit-sum tree.
// Ports: clk, reset (sync, active-high), in[WIDTH-1:0], i_valid -> out[1:0], o_valid.
// Macro SYN_MOD3_PIPE_EN registers out/o_valid at the tree root (1-cycle latency);
// without it the block is purely combinational and clk/reset are ignored.
module syn_mod3 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             i_valid,
  output logic [1:0]       out,
  output logic             o_valid
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("syn_mod3: WIDTH must be in 1..32");
  end

  // Number of base-4 digits after padding to an even width.
  localparam int D  = (WIDTH + 1) / 2;
  localparam int EW = 2 * D;

  function automatic int tree_levels(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 1) begin
      m = (m + 1) / 2;
      l++;
    end
    return l;
  endfunction

  function automatic int level_nodes(input int l);
    int m;
    m = D;
    for (int i = 0; i < l; i++) begin
      m = (m + 1) / 2;
    end
    return m;
  endfunction

  localparam int LV = tree_levels(D);

  // 4 == 1 (mod 3), so each base-4 digit contributes its own residue.
  function automatic logic [1:0] norm3(input logic [1:0] d);
    return (d == 2'd3) ? 2'd0 : d;
  endfunction

  // (a + b) mod 3 for residues a, b in 0..2.
  function automatic logic [1:0] add3(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [1:0] s;
    case ({a, b})
      4'h0:    s = 2'd0;
      4'h1:    s = 2'd1;
      4'h2:    s = 2'd2;
      4'h4:    s = 2'd1;
      4'h5:    s = 2'd2;
      4'h6:    s = 2'd0;
      4'h8:    s = 2'd2;
      4'h9:    s = 2'd0;
      4'hA:    s = 2'd1;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

  logic [EW-1:0] op;
  logic [1:0]    tree [LV+1][D];
  logic [1:0]    root;

  assign op = EW'(in);

  for (genvar k = 0; k < D; k++) begin : g_leaf
    assign tree[0][k] = norm3(op[2*k +: 2]);
  end

  for (genvar l = 1; l <= LV; l++) begin : g_lvl
    localparam int NP = level_nodes(l - 1);
    localparam int NC = level_nodes(l);
    for (genvar k = 0; k < D; k++) begin : g_node
      if (k < NC && (2 * k + 1) < NP) begin : g_add
        assign tree[l][k] = add3(tree[l-1][2*k], tree[l-1][2*k+1]);
      end else if (k < NC) begin : g_pass
        // Odd leftover node carries straight up.
        assign tree[l][k] = tree[l-1][2*k];
      end else begin : g_idle
        assign tree[l][k] = 2'd0;
      end
    end
  end

  assign root = tree[LV][0];

`ifdef SYN_MOD3_PIPE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= 2'd0;
      o_valid <= 1'b0;
    end else begin
      out     <= root;
      o_valid <= i_valid;
    end
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
  assign out     = root;
  assign o_valid = i_valid;
`endif

endmodule

// File: tb/tb_syn_mod3.sv
// tb_syn_mod3: directed table + sweeps + random checks of syn_mod3 at several widths.
// Works for both the combinational and the SYN_MOD3_PIPE_EN builds.
module tb_syn_mod3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        iv;

  logic [1:0] o8, o32, o1, o3, o31, o5;
  logic       v8, v32, v1, v3, v31, v5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  syn_mod3 #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .in(din[7:0]), .i_valid(iv),
    .out(o8), .o_valid(v8)
  );
  syn_mod3 #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .in(din), .i_valid(iv),
    .out(o32), .o_valid(v32)
  );
  syn_mod3 #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .in(din[0:0]), .i_valid(iv),
    .out(o1), .o_valid(v1)
  );
  syn_mod3 #(.WIDTH(3)) u3 (
    .clk(clk), .reset(reset), .in(din[2:0]), .i_valid(iv),
    .out(o3), .o_valid(v3)
  );
  syn_mod3 #(.WIDTH(31)) u31 (
    .clk(clk), .reset(reset), .in(din[30:0]), .i_valid(iv),
    .out(o31), .o_valid(v31)
  );
  syn_mod3 #(.WIDTH(5)) u5 (
    .clk(clk), .reset(reset), .in(din[4:0]), .i_valid(iv),
    .out(o5), .o_valid(v5)
  );

  typedef struct {
    int          sel;
    logic [31:0] din;
    logic [1:0]  exp;
    string       name;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [1:0] pick(input int sel);
    case (sel)
      0:       return o8;
      1:       return o32;
      2:       return o1;
      3:       return o3;
      4:       return o31;
      default: return o5;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  // Let the applied inputs reach the outputs.
  task automatic settle();
`ifdef SYN_MOD3_PIPE_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    tbl[0]  = '{0, 32'd0,          2'd0, "w8_0"};
    tbl[1]  = '{0, 32'd7,          2'd1, "w8_7"};
    tbl[2]  = '{0, 32'd254,        2'd2, "w8_254"};
    tbl[3]  = '{0, 32'd255,        2'd0, "w8_255"};
    tbl[4]  = '{1, 32'hFFFFFFFF,   2'd0, "w32_ones"};
    tbl[5]  = '{1, 32'h80000000,   2'd2, "w32_msb"};
    tbl[6]  = '{1, 32'h00000001,   2'd1, "w32_one"};
    // 16 digits of value 2 sum to 32, and 32 mod 3 = 2.
    tbl[7]  = '{1, 32'hAAAAAAAA,   2'd2, "w32_aaaa"};
    tbl[8]  = '{1, 32'h12345678,   2'd0, "w32_12345678"};
    tbl[9]  = '{1, 32'hFFFFFFFE,   2'd2, "w32_fffe"};
    tbl[10] = '{1, 32'h00000000,   2'd0, "w32_zero"};
    tbl[11] = '{2, 32'd1,          2'd1, "w1_1"};
    tbl[12] = '{2, 32'd0,          2'd0, "w1_0"};
    tbl[13] = '{3, 32'd7,          2'd1, "w3_7"};
    tbl[14] = '{3, 32'd6,          2'd0, "w3_6"};
    tbl[15] = '{4, 32'h7FFFFFFF,   2'd1, "w31_ones"};
    tbl[16] = '{5, 32'd31,         2'd1, "w5_31"};

    reset = 1'b1;
    din   = 32'd0;
    iv    = 1'b0;
    settle();
    settle();
    chk("reset_out", o8, 2'd0);
    chkb("reset_valid", v8, 1'b0);
    reset = 1'b0;
    iv    = 1'b1;

    foreach (tbl[i]) begin
      din = tbl[i].din;
      settle();
      chk(tbl[i].name, pick(tbl[i].sel), tbl[i].exp);
    end

    for (int i = 0; i < 256; i++) begin
      din = 32'(i);
      settle();
      chk($sformatf("w8_sweep_%0d", i), o8, 2'(i % 3));
    end

    for (int i = 0; i < 32; i++) begin
      din = 32'(i);
      settle();
      chk($sformatf("w5_sweep_%0d", i), o5, 2'(i % 3));
    end

    for (int i = 0; i < 10000; i++) begin
      din = $urandom;
      settle();
      chk($sformatf("w32_rand_%08h", din), o32, 2'(din % 32'd3));
    end

    din = 32'd8;
    iv  = 1'b0;
    settle();
    chkb("valid_low", v8, 1'b0);
    chk("out_valid_low", o8, 2'd2);
    iv = 1'b1;
    settle();
    chkb("valid_high", v8, 1'b1);
    iv = 1'b0;
    settle();
    chkb("valid_low2", v32, 1'b0);

`ifdef SYN_MOD3_PIPE_EN
    din = 32'd0;
    iv  = 1'b0;
    settle();
    din = 32'd254;
    iv  = 1'b1;
    #2;
    chk("lat_hold_out", o8, 2'd0);
    chkb("lat_hold_valid", v8, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_out", o8, 2'd2);
    chkb("lat_valid", v8, 1'b1);

    for (int i = 0; i < 4; i++) begin
      din = 32'(i);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_%0d", i), o32, 2'(i % 3));
    end

    din = 32'd5;
    settle();
    chk("pre_reset", o8, 2'd2);
    reset = 1'b1;
    settle();
    chk("rst_out", o8, 2'd0);
    chkb("rst_valid", v8, 1'b0);
    reset = 1'b0;
    settle();
    chk("post_rst_out", o8, 2'd2);
    chkb("post_rst_valid", v8, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
